tcdm_g_master: RTL and testbench
================================

TCDM_G_MASTER -- requirements
Module: tcdm_g_master

Interface
REQ-001 Parameter ADDR_SRAM_WIDTH, default 10, SRAM row (word) address width.
REQ-002 Parameter DATA_WIDTH, default 32, per-bank data width.
REQ-003 Parameter BE_WIDTH, default DATA_WIDTH/8, per-bank byte-enable width.
REQ-004 Parameter SIZE, default 1, number of grouped banks; wide word = SIZE*DATA_WIDTH.
REQ-005 Parameter LEN_WIDTH, default 16, burst length counter width.
REQ-006 One clock, clk; reset rst_n is asynchronous and active-low.
REQ-007 clk  in  1  clock.
REQ-008 rst_n  in  1  async active-low reset.
REQ-009 start  in  1  one-cycle burst launch; sampled only in IDLE.
REQ-010 cfg_addr  in  ADDR_SRAM_WIDTH  first row address.
REQ-011 cfg_len  in  LEN_WIDTH  number of wide accesses; 0 = empty burst.
REQ-012 cfg_wen  in  1  0 = store burst, 1 = load burst.
REQ-013 busy  out  1  high whenever state is not IDLE.
REQ-014 done  out  1  one-cycle pulse at burst completion.
REQ-015 wr_valid / wr_ready  in / out  1 / 1  store-data stream handshake.
REQ-016 wr_data / wr_be  in  SIZE*DATA_WIDTH / SIZE*BE_WIDTH  store data and byte enables.
REQ-017 rd_valid / rd_ready  out / in  1 / 1  load-data stream handshake.
REQ-018 rd_data  out  SIZE*DATA_WIDTH  load data.
REQ-019 data_req_SRAM, data_add_SRAM, data_wen_SRAM  out  1, ADDR_SRAM_WIDTH, 1  grouped SRAM request.
REQ-020 data_wdata_SRAM / data_be_SRAM  out  SIZE*DATA_WIDTH / SIZE*BE_WIDTH  grouped SRAM store data and byte enables.
REQ-021 data_r_rdata_SRAM  in  SIZE*DATA_WIDTH  load data, valid exactly one cycle after a request with data_wen_SRAM=1.

Function
REQ-022 FSM states: IDLE, WRITE, READ, DRAIN.
REQ-023 IDLE + start: cfg_len=0 -> stay IDLE, pulse done next cycle, no request; else latch addr/len -> WRITE (cfg_wen=0) or READ (cfg_wen=1).
REQ-024 start while busy is ignored.
REQ-025 The SRAM grants every request in the same cycle; there is no stall input.
REQ-026 WRITE: wr_ready=1; data_req_SRAM=wr_valid, data_wen_SRAM=0, wdata/be passed combinationally from wr_data/wr_be.
REQ-027 Each request increments the address by 1, modulo 2^ADDR_SRAM_WIDTH (0x3FF -> 0x000), and decrements the remaining count.
REQ-028 WRITE: the last handshake moves the FSM to IDLE and pulses done in the following cycle.
REQ-029 READ: 2-entry read FIFO; a pending flag marks an issued read whose data returns next cycle; returned data is written into the FIFO in that cycle.
REQ-030 READ: issue (data_req_SRAM=1, data_wen_SRAM=1) when fifo_count+pending < 2, or when it equals 2 and rd_valid&&rd_ready in the same cycle.
REQ-031 READ: the last issue moves the FSM to DRAIN.
REQ-032 DRAIN -> IDLE with done pulse when pending=0 and the FIFO is empty after the pop.
REQ-033 rd_valid = FIFO not empty; rd_data = FIFO head; first read data is visible 2 cycles after issue.
REQ-034 With rd_ready held high, reads sustain one request per cycle.
REQ-035 The FIFO never overflows; with rd_ready low it holds 2 entries and requests stop.
REQ-036 Outside active issue: data_req_SRAM=0, data_wen_SRAM=1, data_add_SRAM holds its last value.

Reset
REQ-037 rst_n low asynchronously forces: IDLE, FIFO empty, pending=0, busy=0, done=0, data_req_SRAM=0, data_wen_SRAM=1, data_add_SRAM=0, rd_valid=0, wr_ready=0.
REQ-038 Reset mid-burst aborts the burst; no done pulse, and no requests until the next start.

Verification
REQ-039 Store, addr=0x010, len=4, wr_valid always high -> 4 requests, addresses 0x010..0x013, wen=0; done 1 cycle after the 4th.
REQ-040 Load, addr=0x3FE, len=4, rd_ready=1 -> addresses 0x3FE, 0x3FF, 0x000, 0x001 on consecutive cycles; 4 rd beats in order; single done.
REQ-041 Load, len=8, rd_ready low for 5 cycles -> at most 2 issues; FIFO holds 2; after release, all 8 beats arrive with no loss or duplication.
REQ-042 start with len=0 -> no data_req_SRAM; done 1 cycle later; busy stays 0.
REQ-043 start asserted during a busy burst -> ignored; cfg changes have no effect.
REQ-044 rst_n low mid-load (after 3 of 6 issued) -> immediate IDLE; rd_valid=0; no done pulse.

Source files
------------

// File: rtl/tcdm_g_master.sv
// Burst master for a group of SIZE TCDM banks addressed as one wide row.
// Stores stream straight through to the SRAM; loads are buffered in a 2-entry FIFO.
module tcdm_g_master #(
    parameter int ADDR_SRAM_WIDTH = 10,
    parameter int DATA_WIDTH      = 32,
    parameter int BE_WIDTH        = DATA_WIDTH / 8,
    parameter int SIZE            = 1,
    parameter int LEN_WIDTH       = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [ADDR_SRAM_WIDTH-1:0]   cfg_addr,
    input  logic [LEN_WIDTH-1:0]         cfg_len,
    input  logic                         cfg_wen,
    output logic                         busy,
    output logic                         done,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [SIZE*DATA_WIDTH-1:0]   wr_data,
    input  logic [SIZE*BE_WIDTH-1:0]     wr_be,
    output logic                         rd_valid,
    input  logic                         rd_ready,
    output logic [SIZE*DATA_WIDTH-1:0]   rd_data,
    output logic                         data_req_SRAM,
    output logic [ADDR_SRAM_WIDTH-1:0]   data_add_SRAM,
    output logic                         data_wen_SRAM,
    output logic [SIZE*DATA_WIDTH-1:0]   data_wdata_SRAM,
    output logic [SIZE*BE_WIDTH-1:0]     data_be_SRAM,
    input  logic [SIZE*DATA_WIDTH-1:0]   data_r_rdata_SRAM,
    output logic [1:0]                   dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t                       state_q;
    logic [ADDR_SRAM_WIDTH-1:0]   cur_addr_q;
    logic [ADDR_SRAM_WIDTH-1:0]   last_addr_q;
    logic [LEN_WIDTH-1:0]         len_q;
    logic                         done_q;
    logic                         pend_q;
    logic [1:0]                   cnt_q;
    logic [1:0]                   cnt_d;
    logic                         wr_ptr_q;
    logic                         rd_ptr_q;
    logic [SIZE*DATA_WIDTH-1:0]   fifo_q [2];

    logic       pop;
    logic       w_issue;
    logic       r_issue;
    logic       issue;
    logic       last_beat;
    logic [1:0] occ;

    assign pop       = (cnt_q != 2'd0) && rd_ready;
    assign occ       = cnt_q + {1'b0, pend_q};
    assign w_issue   = (state_q == WRITE) && wr_valid;
    // A full FIFO+pending slot may still issue when a pop frees an entry this cycle.
    assign r_issue   = (state_q == READ) && ((occ < 2'd2) || ((occ == 2'd2) && pop));
    assign issue     = w_issue || r_issue;
    assign last_beat = (len_q == LEN_WIDTH'(1));
    assign cnt_d     = cnt_q + {1'b0, pend_q} - {1'b0, pop};

    assign data_req_SRAM   = issue;
    assign data_wen_SRAM   = ~w_issue;
    assign data_add_SRAM   = issue ? cur_addr_q : last_addr_q;
    assign data_wdata_SRAM = wr_data;
    assign data_be_SRAM    = wr_be;
    assign wr_ready        = (state_q == WRITE);
    assign rd_valid        = (cnt_q != 2'd0);
    assign rd_data         = fifo_q[rd_ptr_q];
    assign busy            = (state_q != IDLE);
    assign done            = done_q;
    assign dbg_state_o     = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            last_addr_q <= '0;
            len_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (issue) begin
                last_addr_q <= cur_addr_q;
                cur_addr_q  <= cur_addr_q + ADDR_SRAM_WIDTH'(1);
                len_q       <= len_q - LEN_WIDTH'(1);
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (cfg_len == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            cur_addr_q <= cfg_addr;
                            len_q      <= cfg_len;
                            state_q    <= cfg_wen ? READ : WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (w_issue && last_beat) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                READ: begin
                    if (r_issue && last_beat) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!pend_q && (cnt_d == 2'd0)) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Read data returns one cycle after issue and is captured in that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q    <= 1'b0;
            cnt_q     <= 2'd0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
        end else begin
            pend_q <= r_issue;
            cnt_q  <= cnt_d;
            if (pend_q) begin
                fifo_q[wr_ptr_q] <= data_r_rdata_SRAM;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

endmodule

// File: tb/tb_tcdm_g_master.sv
// Bench for tcdm_g_master: SRAM model, address/data expectation queues, directed and random bursts.
module tb_tcdm_g_master;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] cfg_addr;
    logic [LW-1:0] cfg_len;
    logic          cfg_wen;
    logic          busy;
    logic          done;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_data;
    logic [BW-1:0] wr_be;
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic          data_req_SRAM;
    logic [AW-1:0] data_add_SRAM;
    logic          data_wen_SRAM;
    logic [DW-1:0] data_wdata_SRAM;
    logic [BW-1:0] data_be_SRAM;
    logic [DW-1:0] data_r_rdata_SRAM;
    logic [1:0]    dbg_state_o;

    tcdm_g_master #(
        .ADDR_SRAM_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .SIZE(1), .LEN_WIDTH(LW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_addr(cfg_addr), .cfg_len(cfg_len),
        .cfg_wen(cfg_wen), .busy(busy), .done(done), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_data(wr_data), .wr_be(wr_be), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_data(rd_data), .data_req_SRAM(data_req_SRAM), .data_add_SRAM(data_add_SRAM),
        .data_wen_SRAM(data_wen_SRAM), .data_wdata_SRAM(data_wdata_SRAM),
        .data_be_SRAM(data_be_SRAM), .data_r_rdata_SRAM(data_r_rdata_SRAM),
        .dbg_state_o(dbg_state_o)
    );

    always #5 clk = ~clk;

    // SRAM model: grants every request, load data valid the cycle after the request.
    logic [DW-1:0] mem [1024];
    always @(posedge clk) begin
        if (data_req_SRAM) begin
            if (data_wen_SRAM) begin
                data_r_rdata_SRAM <= mem[data_add_SRAM];
            end else begin
                for (int b = 0; b < BW; b++) begin
                    if (data_be_SRAM[b]) mem[data_add_SRAM][8*b +: 8] <= data_wdata_SRAM[8*b +: 8];
                end
            end
        end
    end

    int            checks = 0;
    int            passed = 0;
    int            cyc_n = 0;
    int            n_req, n_done, first_req, last_req, done_cyc;
    bit            hs_w;
    bit            exp_wen;
    logic [AW-1:0] exp_addr_q [$];
    logic [DW-1:0] exp_rd_q [$];
    logic [DW-1:0] wq [$];
    logic [DW-1:0] ref_mem [1024];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Called just after a negedge with inputs already driven; samples, then advances one cycle.
    task automatic cyc();
        #1;
        hs_w = wr_valid && wr_ready;
        if (data_req_SRAM) begin
            n_req++;
            if (first_req < 0) first_req = cyc_n;
            last_req = cyc_n;
            check("req_in_burst", 64'(exp_addr_q.size() != 0), 64'd1);
            if (exp_addr_q.size() != 0) begin
                check("req_addr", 64'(data_add_SRAM), 64'(exp_addr_q.pop_front()));
                check("req_wen", 64'(data_wen_SRAM), 64'(exp_wen));
            end
        end
        if (rd_valid && rd_ready) begin
            check("rd_in_burst", 64'(exp_rd_q.size() != 0), 64'd1);
            if (exp_rd_q.size() != 0) check("rd_data", 64'(rd_data), 64'(exp_rd_q.pop_front()));
        end
        if (done) begin
            n_done++;
            done_cyc = cyc_n;
        end
        @(negedge clk);
        cyc_n++;
    endtask

    task automatic start_burst(input logic [AW-1:0] addr, input int len, input bit wen);
        n_req = 0;
        n_done = 0;
        first_req = -1;
        last_req = -1;
        exp_wen = wen;
        wq.delete();
        for (int i = 0; i < len; i++) begin
            logic [AW-1:0] a;
            a = AW'(int'(addr) + i);
            exp_addr_q.push_back(a);
            if (wen) begin
                exp_rd_q.push_back(ref_mem[a]);
            end else begin
                wq.push_back($urandom);
                ref_mem[a] = wq[i];
            end
        end
        cfg_addr = addr;
        cfg_len = LW'(len);
        cfg_wen = wen;
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic settle_and_check(input string tag, input int len);
        for (int i = 0; i < 3; i++) cyc();
        check({tag, "_reqs"}, 64'(n_req), 64'(len));
        check({tag, "_done_count"}, 64'(n_done), 64'd1);
        check({tag, "_addr_left"}, 64'(exp_addr_q.size()), 64'd0);
        check({tag, "_rd_left"}, 64'(exp_rd_q.size()), 64'd0);
        check({tag, "_busy_after"}, 64'(busy), 64'd0);
    endtask

    task automatic run_store(input logic [AW-1:0] addr, input int len, input bit rnd_valid,
                             input bit inject_start);
        int idx;
        start_burst(addr, len, 1'b0);
        idx = 0;
        for (int c = 0; c < 400 && n_done == 0; c++) begin
            wr_valid = (idx < len) && (!rnd_valid || ($urandom_range(0, 1) == 1));
            wr_data = (idx < len) ? wq[idx] : $urandom;
            if (inject_start && idx == 2) begin
                start = 1'b1;
                cfg_addr = AW'($urandom);
                cfg_len = LW'(7);
                cfg_wen = 1'b1;
            end else begin
                start = 1'b0;
            end
            cyc();
            if (hs_w) idx++;
        end
        wr_valid = 1'b0;
        start = 1'b0;
        check("store_done_latency", 64'(done_cyc - last_req), 64'd1);
        settle_and_check("store", len);
    endtask

    task automatic run_load(input logic [AW-1:0] addr, input int len, input int mode);
        start_burst(addr, len, 1'b1);
        for (int c = 0; c < 400 && n_done == 0; c++) begin
            case (mode)
                0: rd_ready = 1'b1;
                1: rd_ready = ($urandom_range(0, 2) != 0);
                default: rd_ready = (c >= 5);
            endcase
            cyc();
            if (mode == 2 && c == 4) begin
                check("stall_issues", 64'(n_req), 64'd2);
                check("stall_rd_valid", 64'(rd_valid), 64'd1);
            end
        end
        rd_ready = 1'b1;
        if (mode == 0) check("load_back_to_back", 64'(last_req - first_req), 64'(len - 1));
        settle_and_check("load", len);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        cfg_addr = '0;
        cfg_len = '0;
        cfg_wen = 1'b0;
        wr_valid = 1'b0;
        wr_data = '0;
        wr_be = '1;
        rd_ready = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            logic [DW-1:0] v;
            v = $urandom;
            mem[i] <= v;
            ref_mem[i] = v;
        end
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_req", 64'(data_req_SRAM), 64'd0);
        check("rst_wen", 64'(data_wen_SRAM), 64'd1);
        check("rst_addr", 64'(data_add_SRAM), 64'd0);
        check("rst_rd_valid", 64'(rd_valid), 64'd0);
        check("rst_wr_ready", 64'(wr_ready), 64'd0);
        rst_n = 1'b1;
        cyc();

        // Store then load across the address wrap, plus the basic store.
        run_store(AW'('h010), 4, 1'b0, 1'b0);
        run_store(AW'('h3FE), 4, 1'b0, 1'b0);
        run_load(AW'('h3FE), 4, 0);
        run_load(AW'('h010), 4, 0);

        // Back-pressure on the load stream.
        run_load(AW'($urandom), 8, 2);

        // Empty burst.
        start_burst(AW'('h123), 0, 1'b0);
        check("len0_done", 64'(done), 64'd1);
        check("len0_busy", 64'(busy), 64'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("len0_busy_hold", 64'(busy), 64'd0);
        end
        check("len0_reqs", 64'(n_req), 64'd0);
        check("len0_done_count", 64'(n_done), 64'd1);

        // start during a busy store must be ignored.
        run_store(AW'('h200), 6, 1'b0, 1'b1);
        run_load(AW'('h200), 6, 1);

        // Reset after 3 of 6 load issues.
        rd_ready = 1'b1;
        start_burst(AW'('h050), 6, 1'b1);
        for (int c = 0; c < 20 && n_req < 3; c++) cyc();
        check("abort_reqs_before", 64'(n_req), 64'd3);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_rd_valid", 64'(rd_valid), 64'd0);
        check("abort_req", 64'(data_req_SRAM), 64'd0);
        check("abort_addr", 64'(data_add_SRAM), 64'd0);
        exp_addr_q.delete();
        exp_rd_q.delete();
        n_req = 0;
        n_done = 0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        check("abort_no_done", 64'(n_done), 64'd0);
        check("abort_no_req", 64'(n_req), 64'd0);
        check("abort_idle", 64'(busy), 64'd0);

        // Random mixed bursts; loads revisit stored rows via ref_mem.
        for (int t = 0; t < 8; t++) begin
            logic [AW-1:0] a;
            int            l;
            a = AW'($urandom);
            l = $urandom_range(1, 9);
            if ($urandom_range(0, 1) == 1) begin
                run_store(a, l, 1'b1, 1'b0);
                run_load(a, l, $urandom_range(0, 2));
            end else begin
                run_load(a, l, $urandom_range(0, 1));
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
